// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
//   Encodes abstract instruction requests into legal RV32I words and writes
//   them sequentially into instruction memory starting at a base address.
//   Illegal requests are still consumed and written, but as a NOP (0x00000013).
//   A sticky err flag records the error, and err_addr records the address of
//   the first illegal request in the session.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start, base_addr    begin a load session at base_addr (word aligned)
//   req_*               request handshake and instruction fields
//   imem_we/addr/wdata  one-deep write register, held until imem_gnt
//   imem_gnt            memory accepts the presented write this cycle
//   busy, done          session status; done is a one-cycle end pulse
//   err, err_addr       sticky illegal-request flag and first bad address
//   instr_count         words written this session (saturating)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start
// S_RUN    | accepting requests, writing encoded words
// S_DRAIN  | last request accepted, waiting for its write grant
// S_DONE   | one-cycle done pulse, then back to idle
module instr_encoder_loader #(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_class,
  input  logic [3:0]        req_alu_op,
  input  logic [4:0]        req_rd,
  input  logic [4:0]        req_rs1,
  input  logic [4:0]        req_rs2,
  input  logic [31:0]       req_imm,
  input  logic              req_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_gnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr,
  output logic [CNT_W-1:0]  instr_count
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [6:0]  OP_R     = 7'b0110011;
  localparam logic [6:0]  OP_IMM   = 7'b0010011;
  localparam logic [6:0]  OP_LOAD  = 7'b0000011;
  localparam logic [6:0]  OP_STORE = 7'b0100011;
  localparam logic [6:0]  OP_BR    = 7'b1100011;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;
  localparam logic [6:0]  OP_JALR  = 7'b1100111;
  localparam logic [6:0]  OP_LUI   = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] next_addr;
  logic              accept;

  logic signed [31:0] simm;
  logic [2:0]         f3;
  logic [6:0]         alt_f7;
  logic               op_ok;
  logic               is_shift;
  logic               imm12_ok;
  logic               br_ok;
  logic               jal_ok;
  logic [31:0]        enc_raw;
  logic [31:0]        enc_word;
  logic               enc_illegal;

  // A new word may enter the output register when it is empty or being
  // granted this cycle, which allows one word per cycle with imem_gnt high.
  assign req_ready = (state == S_RUN) && (!imem_we || imem_gnt);
  assign accept    = req_valid && req_ready;
  assign busy      = (state != S_IDLE);

  always_comb begin
    simm     = req_imm;
    op_ok    = 1'b1;
    f3       = 3'b000;
    case (req_alu_op)
      4'd0, 4'd1: f3 = 3'b000;
      4'd2:       f3 = 3'b111;
      4'd3:       f3 = 3'b110;
      4'd4:       f3 = 3'b100;
      4'd5:       f3 = 3'b001;
      4'd6, 4'd7: f3 = 3'b101;
      4'd8:       f3 = 3'b010;
      4'd9:       f3 = 3'b011;
      default:    op_ok = 1'b0;
    endcase
    alt_f7   = ((req_alu_op == 4'd1) || (req_alu_op == 4'd7)) ? 7'h20 : 7'h00;
    is_shift = (req_alu_op == 4'd5) || (req_alu_op == 4'd6) || (req_alu_op == 4'd7);
    imm12_ok = (simm >= -32'sd2048) && (simm <= 32'sd2047);
    br_ok    = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !req_imm[0];
    jal_ok   = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !req_imm[0];

    enc_raw     = NOP;
    enc_illegal = 1'b0;
    case (req_class)
      4'd0: begin
        enc_raw     = {alt_f7, req_rs2, req_rs1, f3, req_rd, OP_R};
        enc_illegal = !op_ok;
      end
      4'd1: begin
        if (is_shift) begin
          enc_raw     = {alt_f7, req_imm[4:0], req_rs1, f3, req_rd, OP_IMM};
          enc_illegal = (req_imm > 32'd31);
        end else begin
          enc_raw     = {req_imm[11:0], req_rs1, f3, req_rd, OP_IMM};
          enc_illegal = !op_ok || (req_alu_op == 4'd1) || !imm12_ok;
        end
      end
      4'd2: begin
        enc_raw     = {req_imm[11:0], req_rs1, 3'b010, req_rd, OP_LOAD};
        enc_illegal = !imm12_ok;
      end
      4'd3: begin
        enc_raw     = {req_imm[11:5], req_rs2, req_rs1, 3'b010, req_imm[4:0], OP_STORE};
        enc_illegal = !imm12_ok;
      end
      4'd4: begin
        enc_raw     = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_alu_op[2:0],
                       req_imm[4:1], req_imm[11], OP_BR};
        enc_illegal = !br_ok || (req_alu_op[2:1] == 2'b01);
      end
      4'd5: begin
        enc_raw     = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, OP_JAL};
        enc_illegal = !jal_ok;
      end
      4'd6: begin
        enc_raw     = {req_imm[11:0], req_rs1, 3'b000, req_rd, OP_JALR};
        enc_illegal = !imm12_ok;
      end
      4'd7: begin
        enc_raw     = {req_imm[31:12], req_rd, OP_LUI};
        enc_illegal = (req_imm[11:0] != 12'd0);
      end
      4'd8: begin
        enc_raw     = {req_imm[31:12], req_rd, OP_AUIPC};
        enc_illegal = (req_imm[11:0] != 12'd0);
      end
      default: enc_illegal = 1'b1;
    endcase
    enc_word = enc_illegal ? NOP : enc_raw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      next_addr   <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_addr    <= '0;
      instr_count <= '0;
    end else begin
      done <= 1'b0;

      if (imem_we && imem_gnt) begin
        imem_we <= 1'b0;
        if (instr_count != {CNT_W{1'b1}})
          instr_count <= instr_count + CNT_W'(1);
      end

      // accept only happens in S_RUN; it overrides the grant-side clear above
      if (accept) begin
        imem_we    <= 1'b1;
        imem_addr  <= next_addr;
        imem_wdata <= enc_word;
        next_addr  <= next_addr + ADDR_W'(4);
        if (enc_illegal) begin
          err <= 1'b1;
          if (!err)
            err_addr <= next_addr;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            next_addr   <= base_addr & ~ADDR_W'(3);
            instr_count <= '0;
            err         <= 1'b0;
            err_addr    <= '0;
            state       <= S_RUN;
          end
        end
        S_RUN: begin
          if (accept && req_last)
            state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (imem_we && imem_gnt) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Inverse of the control decoder: takes abstract instruction requests (class, alu_op code, register fields, immediate) and encodes legal RV32I words. Writes them sequentially into instruction memory from a base address. Used by the bench and boot path to build programs that the single-cycle core then fetches and decodes.
- One-deep output register with a grant handshake.
- Sticky error reporting for illegal requests.

Parameters:
ADDR_W, 12, byte-address width of imem_addr; addresses wrap modulo 2^ADDR_W.
CNT_W, 10, width of instr_count; saturates at all-ones.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a load session (sampled only in IDLE)
base_addr  in  ADDR_W  first write address; low 2 bits ignored (forced 0)
req_valid  in  1  request valid
req_ready  out  1  request accepted when req_valid & req_ready
req_class  in  4  0=R,1=I-ALU,2=LW,3=SW,4=BRANCH,5=JAL,6=JALR,7=LUI,8=AUIPC; others illegal
req_alu_op  in  4  ADD0000 SUB0001 AND0010 OR0011 XOR0100 SLL0101 SRL0110 SRA0111 SLT1000 SLTU1001; BRANCH uses [2:0] as funct3
req_rd, req_rs1, req_rs2  in  5 each  register fields
req_imm  in  32  signed immediate / byte offset; LUI/AUIPC take the full value
req_last  in  1  marks final request of session
imem_we  out  1  write valid, held until imem_gnt
imem_addr  out  ADDR_W  write byte address
imem_wdata  out  32  encoded instruction
imem_gnt  in  1  memory accepts write this cycle
busy  out  1  high outside IDLE
done  out  1  one-cycle pulse at session end
err  out  1  sticky illegal-request flag, cleared on start
err_addr  out  ADDR_W  address of first illegal request
instr_count  out  CNT_W  words written this session

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - Async assertion drops imem_we immediately; an in-flight write is abandoned.
- FSM IDLE -> RUN -> DRAIN -> DONE -> IDLE.
  - IDLE: on start, latch {base_addr[ADDR_W-1:2],2'b00} as next address and clear instr_count, err, err_addr; go to RUN.
  - RUN: req_ready = !imem_we | imem_gnt. On accept, the encoded word is registered. imem_we/addr/wdata are valid the next cycle (latency 1). Next address += 4 with wrap.
  - RUN, accept with req_last=1: go to DRAIN and drop req_ready.
  - DRAIN: wait for imem_gnt on the final word, then go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start outside IDLE is ignored. req_valid in IDLE/DRAIN/DONE is not accepted.
- Back-to-back: accept while imem_gnt=1 replaces the output register in the same cycle, giving 1 word/cycle throughput. While imem_we=1 and imem_gnt=0, outputs are held stable.
- instr_count increments on each imem_we & imem_gnt and saturates.
- Encoding (standard RV32I fields):
  - R: opcode 0110011; funct7=0x20 for SUB/SRA, else 0.
  - I-ALU: opcode 0010011; shifts put shamt=imm[4:0] and funct7 (0x20 for SRA).
  - LW: 0000011/f3 010. SW: 0100011/f3 010.
  - BRANCH: 1100011, B-imm. JAL: 1101111, J-imm. JALR: 1100111/f3 000.
  - LUI: 0110111. AUIPC: 0010111; both use U-imm = imm[31:12].
- Illegal request: the word is still consumed and written, but the value written is NOP 0x00000013. err is set; err_addr is captured only if err was 0. Illegal cases:
  - class > 8.
  - Unlisted alu_op code.
  - SUB with I-ALU.
  - Shift imm outside 0..31.
  - I/S/JALR imm outside -2048..2047.
  - Branch funct3 010/011, odd imm, or imm outside -4096..4094.
  - JAL odd imm or imm outside ±1 MiB.
  - LUI/AUIPC imm[11:0] != 0.
- Address wrap: 0xFFC + 4 -> 0x000 with ADDR_W=12. No error is raised on wrap.

Test Plan:
- base 0x100: ADD x3,x1,x2; ADDI x1,x0,5(last) -> writes 0x002081B3@0x100, 0x00500093@0x104. done pulses 1 cycle after the second gnt; instr_count=2.
- SUB x5,x6,x7 and SRAI x1,x1,3 back-to-back with imem_gnt tied 1 -> 0x407302B3 and 0x4030D093 on consecutive cycles; req_ready stays 1.
- SW x2,8(x1); BEQ x1,x2,+8; JAL x1,+16; LUI x5,0x12345000 with imem_gnt held low 3 cycles per word -> 0x0020A423, 0x00208463, 0x010000EF, 0x123452B7. Outputs stay stable while stalled; req_ready=0 while stalled.
- Illegal: ADDI imm=4096 at 0x20C, then BEQ imm=3 -> both write 0x00000013. err=1, err_addr=0x20C (first only).
- base 0xFF8, 3 words -> addresses 0xFF8, 0xFFC, 0x000.
- rst_n low while imem_we=1 and stalled -> imem_we=0 and busy=0 immediately. A subsequent start behaves normally from the new base_addr.
